clkdiv_ratio_detect: RTL

//  Consumer-side companion to the mod-N clock divider. It samples a divided clock
//  (div_in) in the fast clock domain and measures its half-period in clk cycles,

---
 rtl/clkdiv_pkg.sv | 24 ++
 rtl/clkdiv_edge_det.sv | 62 ++++++
 rtl/clkdiv_ratio_detect.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the clock-divider family: ratio-detector FSM state
// encoding and default sizing constants. The mod-N counter benches reuse the
// same defaults so divider and detector agree on the ratio width.
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    // Ratio-detector FSM states; encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } clkdiv_state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_CNT = 4;

    // Bits needed to count consecutive matches from 0 up to lock_cnt inclusive.
    function automatic int match_width(input int lock_cnt);
        return $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/clkdiv_edge_det.sv
// -----------------------------------------------------------------------------
// clkdiv_edge_det
// Registers the divided clock, flags any transition (rising or falling) and
// times the distance between transitions with a saturating run counter.
//
// Ports
//   clk       in   1      fast clock
//   rstn      in   1      synchronous active-low reset
//   div_in    in   1      divided clock, already synchronous to clk
//   clr       in   1      hold the run counter at zero (detector idle)
//   div_edge  out  1      div_in differs from its registered copy this cycle
//   run       out  WIDTH  clk cycles since the last edge, saturating at MAX
// -----------------------------------------------------------------------------
module clkdiv_edge_det #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_in,
    input  logic             clr,
    output logic             div_edge,
    output logic [WIDTH-1:0] run
);

    localparam logic [WIDTH-1:0] RUN_MAX = {WIDTH{1'b1}};

    logic             div_q;
    logic             div_d;
    logic [WIDTH-1:0] run_q;
    logic [WIDTH-1:0] run_d;

    // Edge detect and next run count; an edge reloads 1 so the value seen at
    // the following edge equals the half-period in clk cycles.
    always_comb begin
        div_d    = div_in;
        div_edge = div_in ^ div_q;
        run_d    = run_q;
        if (div_edge) begin
            run_d = WIDTH'(1);
        end else if (clr) begin
            run_d = {WIDTH{1'b0}};
        end else if (run_q == RUN_MAX) begin
            run_d = run_q;
        end else begin
            run_d = run_q + WIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_q <= 1'b0;
            run_q <= {WIDTH{1'b0}};
        end else begin
            div_q <= div_d;
            run_q <= run_d;
        end
    end

    assign run = run_q;

endmodule

// File: rtl/clkdiv_ratio_detect.sv
// -----------------------------------------------------------------------------
// clkdiv_ratio_detect
// Measures the half-period of a divided clock in fast-clock cycles (the
// divider's N), locks after LOCK_CNT consecutive equal half-periods, and
// reports a mismatch against the locked ratio or a stalled div_in.
//
// Ports
//   clk       in   1      fast clock; single clock domain
//   rstn      in   1      synchronous active-low reset
//   div_in    in   1      divided clock, synchronous to clk
//   ratio     out  WIDTH  locked half-period in clk cycles; 0 while unlocked
//   locked    out  1      high while the detector is locked
//   mismatch  out  1      one-cycle pulse: locked half-period changed
//   timeout   out  1      one-cycle pulse: no div_in edge for MAX cycles
// -----------------------------------------------------------------------------
module clkdiv_ratio_detect
    import clkdiv_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_in,
    output logic [WIDTH-1:0] ratio,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);

    localparam int               MW      = match_width(LOCK_CNT);
    localparam logic [WIDTH-1:0] RUN_MAX = {WIDTH{1'b1}};

    logic             div_edge;
    logic [WIDTH-1:0] run;

    clkdiv_state_e    state_q;
    clkdiv_state_e    state_d;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] cand_d;
    logic [MW-1:0]    match_q;
    logic [MW-1:0]    match_d;
    logic [WIDTH-1:0] ratio_q;
    logic [WIDTH-1:0] ratio_d;
    logic             locked_q;
    logic             locked_d;
    logic             mismatch_q;
    logic             mismatch_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             lock_now_s;

    clkdiv_edge_det #(
        .WIDTH (WIDTH)
    ) u_edge_det (
        .clk      (clk),
        .rstn     (rstn),
        .div_in   (div_in),
        .clr      (state_q == ST_IDLE),
        .div_edge (div_edge),
        .run      (run)
    );

    // True when one more matching half-period completes the lock count;
    // compared in int so the increment cannot wrap the narrow match field.
    always_comb begin
        if ((int'(match_q) + 1) >= LOCK_CNT) begin
            lock_now_s = 1'b1;
        end else begin
            lock_now_s = 1'b0;
        end
    end

    // FSM next state. Edges take precedence over the stall timeout, so a
    // half-period of exactly MAX is still measured.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        match_d    = match_q;
        ratio_d    = ratio_q;
        locked_d   = locked_q;
        mismatch_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // First edge only starts timing; there is no half-period yet.
                if (div_edge) begin
                    state_d = ST_TRAIN;
                    cand_d  = {WIDTH{1'b0}};
                    match_d = {MW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAIN: begin
                if (div_edge) begin
                    if (run == cand_q) begin
                        if (lock_now_s) begin
                            state_d  = ST_LOCKED;
                            ratio_d  = run;
                            locked_d = 1'b1;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        // New candidate restarts the streak at one sample.
                        cand_d  = run;
                        match_d = MW'(1);
                        if (LOCK_CNT == 1) begin
                            state_d  = ST_LOCKED;
                            ratio_d  = run;
                            locked_d = 1'b1;
                        end else begin
                            state_d = ST_TRAIN;
                        end
                    end
                end else if (run == RUN_MAX) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    ratio_d   = {WIDTH{1'b0}};
                    cand_d    = {WIDTH{1'b0}};
                    match_d   = {MW{1'b0}};
                end else begin
                    state_d = ST_TRAIN;
                end
            end
            ST_LOCKED: begin
                if (div_edge) begin
                    if (run == ratio_q) begin
                        state_d = ST_LOCKED;
                    end else begin
                        // Drop lock and start training on the new value.
                        state_d    = ST_TRAIN;
                        mismatch_d = 1'b1;
                        locked_d   = 1'b0;
                        ratio_d    = {WIDTH{1'b0}};
                        cand_d     = run;
                        match_d    = MW'(1);
                    end
                end else if (run == RUN_MAX) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    ratio_d   = {WIDTH{1'b0}};
                    cand_d    = {WIDTH{1'b0}};
                    match_d   = {MW{1'b0}};
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                locked_d = 1'b0;
                ratio_d  = {WIDTH{1'b0}};
                cand_d   = {WIDTH{1'b0}};
                match_d  = {MW{1'b0}};
            end
        endcase
    end

    // FSM and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cand_q     <= {WIDTH{1'b0}};
            match_q    <= {MW{1'b0}};
            ratio_q    <= {WIDTH{1'b0}};
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            match_q    <= match_d;
            ratio_q    <= ratio_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ratio    = ratio_q;
    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign timeout  = timeout_q;

endmodule
